// File: rtl/shift_pkg.sv
// Shared decode constants, FSM state and shift-mode encodings for the iterative shift unit.
package shift_pkg;

    localparam logic [5:0] FUNCT_SLL  = 6'h00;
    localparam logic [5:0] FUNCT_SRL  = 6'h02;
    localparam logic [5:0] FUNCT_SRA  = 6'h03;
    localparam logic [5:0] FUNCT_SLLV = 6'h04;
    localparam logic [5:0] FUNCT_SRLV = 6'h06;
    localparam logic [5:0] FUNCT_SRAV = 6'h07;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        LEFT,
        RIGHT_LOG,
        RIGHT_ARITH
    } mode_t;

endpackage

// File: rtl/shift_decode.sv
// Combinational R-type funct decoder: flags shift ops, picks the amount source and direction.
// Zero latency; no handshake, so it never stalls.
module shift_decode
    import shift_pkg::*;
(
    input  logic [5:0] i_funct,
    output logic       o_is_shift,
    output logic       o_uses_shamt,
    output mode_t      o_mode
);

    always_comb begin
        o_is_shift   = 1'b0;
        o_uses_shamt = 1'b0;
        o_mode       = LEFT;
        case (i_funct)
            FUNCT_SLL: begin
                o_is_shift   = 1'b1;
                o_uses_shamt = 1'b1;
                o_mode       = LEFT;
            end
            FUNCT_SRL: begin
                o_is_shift   = 1'b1;
                o_uses_shamt = 1'b1;
                o_mode       = RIGHT_LOG;
            end
            FUNCT_SRA: begin
                o_is_shift   = 1'b1;
                o_uses_shamt = 1'b1;
                o_mode       = RIGHT_ARITH;
            end
            FUNCT_SLLV: begin
                o_is_shift = 1'b1;
                o_mode     = LEFT;
            end
            FUNCT_SRLV: begin
                o_is_shift = 1'b1;
                o_mode     = RIGHT_LOG;
            end
            FUNCT_SRAV: begin
                o_is_shift = 1'b1;
                o_mode     = RIGHT_ARITH;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/shift_unit_iter.sv
// Multi-cycle shifter: start/done handshake, shifts up to STEP bits per cycle.
// Latency ceil(n/STEP)+1 cycles (1 for n=0 or illegal); start is ignored while busy.
module shift_unit_iter
    import shift_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int STEP  = 1,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [AMT_W-1:0] shamt,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             is_shift,
    output logic             uses_shamt,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic [WIDTH-1:0] result
);

    localparam logic [AMT_W:0] STEP_W = (AMT_W+1)'(STEP);

    logic             w_is_shift;
    logic             w_uses_shamt;
    mode_t            w_mode;
    logic [AMT_W-1:0] w_amt;
    logic [AMT_W-1:0] w_k;
    logic [WIDTH-1:0] w_fill;
    logic [WIDTH-1:0] w_shifted;
    logic             w_unused_rs;

    state_t           r_state,   w_state_nxt;
    logic [WIDTH-1:0] r_acc,     w_acc_nxt;
    logic [AMT_W-1:0] r_rem,     w_rem_nxt;
    mode_t            r_mode,    w_mode_nxt;
    logic             r_sign,    w_sign_nxt;
    logic             r_illegal, w_illegal_nxt;
    logic [WIDTH-1:0] r_result;

    shift_decode u_decode (
        .i_funct      (funct),
        .o_is_shift   (w_is_shift),
        .o_uses_shamt (w_uses_shamt),
        .o_mode       (w_mode)
    );

    assign w_amt       = w_uses_shamt ? shamt : rs_val[AMT_W-1:0];
    assign w_unused_rs = ^rs_val[WIDTH-1:AMT_W];

    // Clamp the per-cycle step to what is left so the last cycle lands exactly on zero.
    assign w_k = ({1'b0, r_rem} > STEP_W) ? STEP_W[AMT_W-1:0] : r_rem;

    // Arithmetic fill uses the sign captured at start, not the current acc MSB.
    assign w_fill = (r_mode == RIGHT_ARITH && r_sign) ? ~({WIDTH{1'b1}} >> w_k) : '0;
    assign w_shifted = (r_mode == LEFT) ? (r_acc << w_k) : ((r_acc >> w_k) | w_fill);

    always_comb begin
        w_state_nxt   = r_state;
        w_acc_nxt     = r_acc;
        w_rem_nxt     = r_rem;
        w_mode_nxt    = r_mode;
        w_sign_nxt    = r_sign;
        w_illegal_nxt = r_illegal;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (w_is_shift) begin
                        w_acc_nxt     = rt_val;
                        w_rem_nxt     = w_amt;
                        w_mode_nxt    = w_mode;
                        w_sign_nxt    = rt_val[WIDTH-1];
                        w_illegal_nxt = 1'b0;
                        w_state_nxt   = (w_amt != '0) ? SHIFT : DONE;
                    end else begin
                        w_acc_nxt     = '0;
                        w_rem_nxt     = '0;
                        w_illegal_nxt = 1'b1;
                        w_state_nxt   = DONE;
                    end
                end
            end
            SHIFT: begin
                w_acc_nxt = w_shifted;
                w_rem_nxt = r_rem - w_k;
                if (r_rem == w_k) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_acc     <= '0;
            r_rem     <= '0;
            r_mode    <= LEFT;
            r_sign    <= 1'b0;
            r_illegal <= 1'b0;
            r_result  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_acc     <= w_acc_nxt;
            r_rem     <= w_rem_nxt;
            r_mode    <= w_mode_nxt;
            r_sign    <= w_sign_nxt;
            r_illegal <= w_illegal_nxt;
            // Result is captured on entry to DONE so it is valid alongside the done pulse.
            if (w_state_nxt == DONE) begin
                r_result <= w_acc_nxt;
            end
        end
    end

    assign is_shift   = w_is_shift;
    assign uses_shamt = w_uses_shamt;
    assign busy       = (r_state != IDLE);
    assign done       = (r_state == DONE);
    assign illegal    = (r_state == DONE) && r_illegal;
    assign result     = r_result;

endmodule

// File: tb/tb_shift_unit_iter.sv
// Scoreboard bench for shift_unit_iter with STEP=1 and STEP=4 instances.
module tb_shift_unit_iter;

    typedef struct {
        logic [31:0] res;
        logic        ill;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start1, start4;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] rs_val, rt_val;

    logic        is_shift1, uses_shamt1, busy1, done1, illegal1;
    logic [31:0] result1;
    logic        is_shift4, uses_shamt4, busy4, done4, illegal4;
    logic [31:0] result4;

    logic        sel4;
    logic        o_busy, o_done, o_illegal;
    logic [31:0] o_result;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    shift_unit_iter #(.WIDTH(32), .STEP(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .funct(funct), .shamt(shamt),
        .rs_val(rs_val), .rt_val(rt_val), .is_shift(is_shift1), .uses_shamt(uses_shamt1),
        .busy(busy1), .done(done1), .illegal(illegal1), .result(result1)
    );

    shift_unit_iter #(.WIDTH(32), .STEP(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .funct(funct), .shamt(shamt),
        .rs_val(rs_val), .rt_val(rt_val), .is_shift(is_shift4), .uses_shamt(uses_shamt4),
        .busy(busy4), .done(done4), .illegal(illegal4), .result(result4)
    );

    always_comb begin
        o_busy    = sel4 ? busy4    : busy1;
        o_done    = sel4 ? done4    : done1;
        o_illegal = sel4 ? illegal4 : illegal1;
        o_result  = sel4 ? result4  : result1;
    end

    function automatic bit m_is_shift(input logic [5:0] f);
        return f inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
    endfunction

    function automatic int m_amt(input logic [5:0] f, input logic [4:0] sh, input logic [31:0] rs);
        return f[2] ? int'(rs[4:0]) : int'(sh);
    endfunction

    function automatic logic [31:0] m_res(input logic [5:0] f, input logic [4:0] sh,
                                          input logic [31:0] rs, input logic [31:0] rt);
        int n;
        logic [31:0] r;
        if (!m_is_shift(f)) return 32'h0;
        n = m_amt(f, sh, rs);
        case (f[1:0])
            2'b00:   r = rt << n;
            2'b10:   r = rt >> n;
            default: r = 32'($signed(rt) >>> n);
        endcase
        return r;
    endfunction

    function automatic int m_cyc(input logic [5:0] f, input logic [4:0] sh,
                                 input logic [31:0] rs, input int step);
        int n;
        if (!m_is_shift(f)) return 1;
        n = m_amt(f, sh, rs);
        if (n == 0) return 1;
        return (n + step - 1) / step + 1;
    endfunction

    task automatic run_op(input bit s4, input logic [5:0] f, input logic [4:0] sh,
                          input logic [31:0] rs, input logic [31:0] rt, input bit hold,
                          input string name, output int busy_cnt);
        exp_t e;
        int   c;
        bit   got;
        sel4  = s4;
        e.res = m_res(f, sh, rs, rt);
        e.ill = !m_is_shift(f);
        e.cyc = m_cyc(f, sh, rs, s4 ? 4 : 1);
        sb.push_back(e);
        @(negedge clk);
        funct = f; shamt = sh; rs_val = rs; rt_val = rt;
        if (s4) start4 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) begin start1 = 1'b0; start4 = 1'b0; end
        c = 1; got = 1'b0; busy_cnt = 0;
        while (!got && c <= 200) begin
            @(negedge clk);
            if (o_busy) busy_cnt++;
            if (o_done) got = 1'b1;
            else begin
                @(posedge clk);
                #1;
                if (hold) rt_val = $urandom;
                c++;
            end
        end
        e = sb.pop_front();
        n_vec++;
        if (!got) begin
            n_err++;
            $display("FAIL %s timeout: no done within %0d cycles, expected done in cycle %0d", name, c - 1, e.cyc);
        end else begin
            if (c !== e.cyc) begin
                n_err++;
                $display("FAIL %s done_cycle: got %0d expected %0d", name, c, e.cyc);
            end
            n_vec++;
            if (o_result !== e.res) begin
                n_err++;
                $display("FAIL %s result: got %08h expected %08h", name, o_result, e.res);
            end
            n_vec++;
            if (o_illegal !== e.ill) begin
                n_err++;
                $display("FAIL %s illegal: got %b expected %b", name, o_illegal, e.ill);
            end
        end
        @(posedge clk);
        #1;
        start1 = 1'b0; start4 = 1'b0;
        @(negedge clk);
        n_vec++;
        if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s after_done: done=%b busy=%b expected 0 0", name, o_done, o_busy);
        end
        n_vec++;
        if (o_result !== e.res) begin
            n_err++;
            $display("FAIL %s result_hold: got %08h expected %08h", name, o_result, e.res);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start1 = 1'b0; start4 = 1'b0; sel4 = 1'b0;
        funct = 6'h03; shamt = '0; rs_val = '0; rt_val = '0;
        #1;
        n_vec++;
        if ({busy1, done1, illegal1, result1} !== 35'h0) begin
            n_err++;
            $display("FAIL reset_dut1: busy=%b done=%b illegal=%b result=%08h expected all 0", busy1, done1, illegal1, result1);
        end
        n_vec++;
        if ({busy4, done4, illegal4, result4} !== 35'h0) begin
            n_err++;
            $display("FAIL reset_dut4: busy=%b done=%b illegal=%b result=%08h expected all 0", busy4, done4, illegal4, result4);
        end
        n_vec++;
        if (is_shift1 !== 1'b1 || uses_shamt1 !== 1'b1) begin
            n_err++;
            $display("FAIL reset_decode_sra: is_shift=%b uses_shamt=%b expected 1 1", is_shift1, uses_shamt1);
        end
        funct = 6'h06;
        #1;
        n_vec++;
        if (is_shift4 !== 1'b1 || uses_shamt4 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_decode_srlv: is_shift=%b uses_shamt=%b expected 1 0", is_shift4, uses_shamt4);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sll_step1();
        int bc;
        run_op(1'b0, 6'h00, 5'd4, 32'h0, 32'h0000_0001, 1'b0, "sll4_step1", bc);
        n_vec++;
        if (bc !== 5) begin
            n_err++;
            $display("FAIL sll4_step1 busy_cycles: got %0d expected 5", bc);
        end
    endtask

    task automatic test_srav_step4();
        int bc;
        funct = 6'h07;
        #1;
        n_vec++;
        if (uses_shamt4 !== 1'b0 || is_shift4 !== 1'b1) begin
            n_err++;
            $display("FAIL srav_decode: uses_shamt=%b is_shift=%b expected 0 1", uses_shamt4, is_shift4);
        end
        run_op(1'b1, 6'h07, 5'd0, 32'hFFFF_FFE5, 32'h8000_0000, 1'b0, "srav5_step4", bc);
    endtask

    task automatic test_zero_and_sllv();
        int bc;
        run_op(1'b0, 6'h02, 5'd0, 32'h0, 32'hDEAD_BEEF, 1'b0, "srl0", bc);
        run_op(1'b0, 6'h04, 5'd7, 32'd31, 32'h0000_0001, 1'b0, "sllv31_step1", bc);
        run_op(1'b1, 6'h04, 5'd7, 32'd31, 32'h0000_0001, 1'b0, "sllv31_step4", bc);
    endtask

    task automatic test_illegal();
        int bc;
        funct = 6'h20;
        #1;
        n_vec++;
        if (is_shift1 !== 1'b0 || uses_shamt1 !== 1'b0) begin
            n_err++;
            $display("FAIL add_decode: is_shift=%b uses_shamt=%b expected 0 0", is_shift1, uses_shamt1);
        end
        run_op(1'b0, 6'h20, 5'd3, 32'h5, 32'h1234_5678, 1'b0, "illegal_add", bc);
    endtask

    task automatic test_back_to_back();
        int bc;
        run_op(1'b0, 6'h02, 5'd8, 32'h0, 32'hA5A5_1234, 1'b1, "srl8_restart", bc);
        run_op(1'b1, 6'h03, 5'd13, 32'h0, 32'h9000_0F0F, 1'b0, "sra13_step4", bc);
    endtask

    task automatic test_reset_mid_shift();
        int bc;
        sel4 = 1'b0;
        @(negedge clk);
        funct = 6'h03; shamt = 5'd20; rs_val = '0; rt_val = 32'hFFFF_0000; start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({busy1, done1, illegal1, result1} !== 35'h0) begin
            n_err++;
            $display("FAIL reset_mid_shift: busy=%b done=%b illegal=%b result=%08h expected all 0", busy1, done1, illegal1, result1);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (done1 !== 1'b0 || busy1 !== 1'b0) begin
                n_err++;
                $display("FAIL reset_hold: done=%b busy=%b expected 0 0", done1, busy1);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            n_vec++;
            if (done1 !== 1'b0) begin
                n_err++;
                $display("FAIL aborted_done: done=%b expected 0 in cycle %0d after release", done1, i);
            end
        end
        run_op(1'b0, 6'h00, 5'd1, 32'h0, 32'h0000_0001, 1'b0, "sll1_after_reset", bc);
    endtask

    task automatic test_random();
        logic [5:0] fs [7];
        int bc;
        fs = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h25};
        for (int i = 0; i < 12; i++) begin
            run_op(i[0], fs[$urandom_range(6)], 5'($urandom), $urandom, $urandom, 1'b0, "random", bc);
        end
    endtask

    initial begin
        test_reset();
        test_sll_step1();
        test_srav_step4();
        test_zero_and_sllv();
        test_illegal();
        test_back_to_back();
        test_reset_mid_shift();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
